// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module      : pll_reset_sequencer
// Description : PLL reset pulse, lock wait with timeout/retry, lock
//               stabilization and downstream core reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       lock_lost_o,
    output logic [7:0] retry_count_o
);

    localparam int MAX_AB     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             lost_d;
    logic             sync1_q, locked_s_q;

    logic [7:0] retry_inc;
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                end
            end
            STABILIZE: begin
                // Any dropout restarts the lock wait with a fresh timeout.
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
                    state_d = RESET_PLL;
                    retry_d = retry_inc;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the transition edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= 8'd0;
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_o     <= 1'b1;
            sys_rst_o     <= 1'b1;
            ready_o       <= 1'b0;
            lock_lost_o   <= 1'b0;
            retry_count_o <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            sync1_q       <= locked_i;
            locked_s_q    <= sync1_q;
            pll_rst_o     <= (state_d == RESET_PLL);
            sys_rst_o     <= (state_d != RUN);
            ready_o       <= (state_d == RUN);
            lock_lost_o   <= lost_d;
            retry_count_o <= retry_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer (4/20/8 timing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst, sys_rst, ready, lock_lost;
    logic [7:0] retry_count;

    pll_reset_sequencer #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked_i     (locked),
        .pll_rst_o    (pll_rst),
        .sys_rst_o    (sys_rst),
        .ready_o      (ready),
        .lock_lost_o  (lock_lost),
        .retry_count_o(retry_count)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    typedef struct packed {
        logic       pll;
        logic       sys;
        logic       rdy;
        logic       lost;
        logic [7:0] retry;
    } exp_t;

    typedef struct {
        logic rst;
        logic locked;
        int   cycles;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference timeline: phase 0 pulse, 1 wait, 2 stabilize, 3 run.
    int   m_phase, m_age, m_retry;
    logic m_sa, m_sb, m_lost;

    function automatic void model_edge(input logic r, input logic l);
        logic seen;
        seen   = m_sb;
        m_lost = 1'b0;
        if (r) begin
            m_phase = 0; m_age = 0; m_retry = 0; m_sa = 0; m_sb = 0;
            return;
        end
        m_sb = m_sa;
        m_sa = l;
        m_age++;
        if (m_phase == 0 && m_age == RC) begin
            m_phase = 1; m_age = 0;
        end else if (m_phase == 1 && seen) begin
            m_phase = 2; m_age = 0;
        end else if (m_phase == 1 && m_age == LT) begin
            m_phase = 0; m_age = 0;
            if (m_retry < 255) m_retry++;
        end else if (m_phase == 2 && !seen) begin
            m_phase = 1; m_age = 0;
        end else if (m_phase == 2 && m_age == SC) begin
            m_phase = 3; m_age = 0;
        end else if (m_phase == 3 && !seen) begin
            m_phase = 0; m_age = 0; m_lost = 1'b1;
            if (m_retry < 255) m_retry++;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pll   = (m_phase == 0);
        e.sys   = (m_phase != 3);
        e.rdy   = (m_phase == 3);
        e.lost  = m_lost;
        e.retry = 8'(m_retry);
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.pll = pll_rst; a.sys = sys_rst; a.rdy = ready; a.lost = lock_lost;
        a.retry = retry_count;
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, predict, then compare against the oldest prediction.
    task automatic step(input logic r, input logic l);
        exp_t e;
        rst    = r;
        locked = l;
        model_edge(r, l);
        sb_q.push_back(model_out());
        @(posedge refclk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (dut_out() !== e) begin
                n_errors++;
                $display("FAIL cycle actual=%h required=%h t=%0t", dut_out(), e, $time);
            end
        end
    endtask

    vec_t vecs[15];
    int   cyc;
    logic seen_ready;

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        m_phase = 0; m_age = 0; m_retry = 0; m_sa = 0; m_sb = 0; m_lost = 0;

        // {rst, locked, cycles, {pll, sys, rdy, lost, retry}} checked after each row
        vecs[0]  = '{1'b1, 1'b1, 3,  '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[1]  = '{1'b0, 1'b1, 4,  '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[2]  = '{1'b0, 1'b1, 8,  '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0}};
        vecs[3]  = '{1'b0, 1'b1, 1,  '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0}};
        vecs[4]  = '{1'b0, 1'b1, 5,  '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0}};
        vecs[5]  = '{1'b0, 1'b0, 2,  '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0}};
        vecs[6]  = '{1'b0, 1'b0, 1,  '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1}};
        vecs[7]  = '{1'b0, 1'b0, 1,  '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1}};
        vecs[8]  = '{1'b0, 1'b0, 2,  '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1}};
        vecs[9]  = '{1'b0, 1'b0, 1,  '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1}};
        vecs[10] = '{1'b0, 1'b0, 19, '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1}};
        vecs[11] = '{1'b0, 1'b0, 1,  '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2}};
        vecs[12] = '{1'b0, 1'b0, 3,  '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2}};
        vecs[13] = '{1'b0, 1'b0, 1,  '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2}};
        vecs[14] = '{1'b0, 1'b0, 20, '{1'b1, 1'b1, 1'b0, 1'b0, 8'd3}};

        @(negedge refclk);
        for (int i = 0; i < 15; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].rst, vecs[i].locked);
            chk($sformatf("vec%0d", i), int'(dut_out()), int'(vecs[i].exp));
        end

        // Single-cycle lock dropout in STABILIZE delays release by a full restabilization.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        cyc = 0;
        seen_ready = 1'b0;
        while (!seen_ready && cyc < 60) begin
            step(1'b0, (cyc == 8) ? 1'b0 : 1'b1);
            cyc++;
            seen_ready = ready;
        end
        chk("dropout_ready_cycle", cyc, 20);
        chk("dropout_retry", int'(retry_count), 0);

        // Lock loss in RUN: single lost pulse, reset pulse of RC cycles.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("run_hold_ready", int'(ready), 1);
        step(1'b0, 1'b0);
        chk("lost_pulse", int'(lock_lost), 1);
        chk("lost_retry", int'(retry_count), 1);
        step(1'b0, 1'b0);
        chk("lost_single", int'(lock_lost), 0);
        for (int c = 0; c < RC - 1; c++) step(1'b0, 1'b0);
        chk("lost_pll_released", int'(pll_rst), 0);

        // Five timeouts, then lock, then rst mid-STABILIZE.
        step(1'b1, 1'b0);
        for (int c = 0; c < 5 * (RC + LT); c++) step(1'b0, 1'b0);
        chk("retry5", int'(retry_count), 5);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1);
        chk("in_stabilize", int'({pll_rst, sys_rst, ready}), 3'b010);
        step(1'b1, 1'b1);
        chk("rst_mid_stab", int'(dut_out()), int'(exp_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));

        // Saturation after more than 256 timeouts.
        for (int c = 0; c < 258 * (RC + LT); c++) step(1'b0, 1'b0);
        chk("retry_saturate", int'(retry_count), 255);
        chk("never_ready", int'(ready), 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: width of PLL reset pulse, in refclk cycles (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK before retry (>=1).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (>=1).
REQ-004 refclk  in  1  sole clock, all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-007 pll_rst  out  1  reset to the PLL instance, active-high.
REQ-008 sys_rst  out  1  reset to the downstream core, active-high.
REQ-009 ready  out  1  high while clocks are stable and core released.
REQ-010 lock_lost  out  1  one-cycle pulse on lock loss in RUN.
REQ-011 retry_count  out  8  number of PLL re-resets since rst, saturating.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer; locked_s (2nd flop) is the only lock signal used by the FSM (2-cycle latency).
REQ-013 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABILIZE, RUN; one shared cycle counter, cleared on every state change.
REQ-014 RESET_PLL: pll_rst=1; occupies exactly RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-015 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABILIZE next cycle (minimum 1 cycle in state); else after LOCK_TIMEOUT cycles -> RESET_PLL and retry_count+1.
REQ-016 STABILIZE: locked_s=0 on any cycle -> WAIT_LOCK (timeout restarts, no retry increment); locked_s=1 for STABLE_CYCLES consecutive cycles -> RUN.
REQ-017 RUN: sys_rst=0, ready=1; locked_s=0 -> RESET_PLL, lock_lost=1 for exactly one cycle, retry_count+1.
REQ-018 sys_rst SHALL be 1 and ready 0 in every state except RUN; pll_rst SHALL be 1 only in RESET_PLL.
REQ-019 All outputs SHALL be registered and reflect the new state in the cycle following the transition edge; no combinational path from locked to any output.
REQ-020 retry_count SHALL saturate at 255 and never wrap.
REQ-021 Counter width SHALL cover max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) with no overflow.

Reset
REQ-022 rst=1 at any edge, in any state, SHALL force: state RESET_PLL, counter 0, synchronizer flops 0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_count=0; rst has priority over all transitions.
REQ-023 After rst release, RESET_PLL SHALL run its full RST_CYCLES from count 0.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
REQ-024 locked held 1, rst released -> pll_rst high exactly 4 cycles, 1 cycle WAIT_LOCK, ready=1/sys_rst=0 from cycle 13 after release; retry_count=0.
REQ-025 locked held 0 -> pll_rst pulses 4 cycles every 24 cycles; retry_count reads 1, 2, 3 after successive timeouts; ready never asserts.
REQ-026 locked low for 1 cycle mid-STABILIZE -> FSM returns to WAIT_LOCK; ready delayed by full 8-cycle restabilization; retry_count unchanged.
REQ-027 In RUN, locked drops -> 2 cycles later state leaves RUN; lock_lost single-cycle pulse, ready=0, sys_rst=1, pll_rst=1 for 4 cycles, retry_count+1.
REQ-028 rst asserted mid-STABILIZE with retry_count=5 -> next edge all outputs at REQ-022 values, retry_count=0.
REQ-029 locked held 0 for 256+ timeouts -> retry_count holds 255.
